// File: rtl/aes_pkg.sv
// Shared AES-128 constants and the round-controller state encoding, used by the
// round controller, the round datapath and the key schedule.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;
    localparam int AES_RND_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

endpackage : aes_pkg

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: one block in flight, NR rounds of STAGE_LAT cycles each,
// valid/ready on both sides; all datapath controls decode from state and counters.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR        = AES_NR,
    parameter int STAGE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 dp_init,
    output logic                 dp_en,
    output logic                 dp_capture,
    output logic [AES_RND_W-1:0] dp_round,
    output logic                 dp_last,
    output logic                 busy
);

    localparam int CNT_W = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STAGE_LAT - 1);
    localparam logic [AES_RND_W-1:0] RND_LAST = AES_RND_W'(NR);

    if (NR < 1 || NR > 15 || STAGE_LAT < 1) begin : g_bad_param
        $error("aes_round_ctrl: NR must be 1..15 and STAGE_LAT >= 1");
    end

    ctrl_state_t          state_q, state_d;
    logic [AES_RND_W-1:0] rnd_q, rnd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        cnt_d      = cnt_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        dp_init    = 1'b0;
        dp_en      = 1'b0;
        dp_capture = 1'b0;
        dp_round   = '0;
        dp_last    = 1'b0;
        busy       = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                dp_init  = in_valid;
                if (in_valid) begin
                    rnd_d   = AES_RND_W'(1);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                dp_en    = 1'b1;
                dp_round = rnd_q;
                dp_last  = (rnd_q == RND_LAST);
                if (cnt_q == CNT_LAST) begin
                    dp_capture = 1'b1;
                    cnt_d      = '0;
                    // The final round keeps rnd so the key schedule index stays stable.
                    if (rnd_q == RND_LAST) state_d = DONE;
                    else                   rnd_d   = rnd_q + AES_RND_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    rnd_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rnd_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    a_init_capture_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(dp_init && dp_capture));

endmodule : aes_round_ctrl

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: cycle-exact control timing plus a behavioural
// AES round/key-schedule model driven by the DUT controls to check FIPS-197 vectors.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst_n, in_valid, out_ready, s_in_valid, s_out_ready;
    logic in_ready, out_valid, dp_init, dp_en, dp_capture, dp_last, busy;
    logic s_in_ready, s_out_valid, s_dp_init, s_dp_en, s_dp_capture, s_dp_last, s_busy;
    logic [3:0] dp_round, s_dp_round;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] pt_r, key_r, dp_state;
    logic [127:0] rk [0:15];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .STAGE_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .dp_init(dp_init), .dp_en(dp_en),
        .dp_capture(dp_capture), .dp_round(dp_round), .dp_last(dp_last), .busy(busy)
    );

    aes_round_ctrl #(.NR(1), .STAGE_LAT(1)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .dp_init(s_dp_init), .dp_en(s_dp_en),
        .dp_capture(s_dp_capture), .dp_round(s_dp_round), .dp_last(s_dp_last), .busy(s_busy)
    );

    logic [10:0] obs, s_obs;
    assign obs   = {in_ready, out_valid, dp_init, dp_en, dp_capture, dp_round, dp_last, busy};
    assign s_obs = {s_in_ready, s_out_valid, s_dp_init, s_dp_en, s_dp_capture, s_dp_round,
                    s_dp_last, s_busy};

    // ---------------- behavioural AES model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Datapath stand-in: follows only the controller's init/capture/round/last outputs.
    always @(posedge clk) begin
        if (dp_init)         dp_state <= pt_r ^ key_r;
        else if (dp_capture) dp_state <= aes_round(dp_state, rk[dp_round], dp_last);
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input logic [127:0] pt, input logic [127:0] key);
        pt_r  = pt;
        key_r = key;
        expand_key(key);
    endtask

    // Handshake one block, wait for out_valid and check latency and ciphertext.
    task automatic run_block(input string name, input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] ct, input logic rdy);
        int lat;
        lat = 0;
        load_block(pt, key);
        next_cyc();
        in_valid  = 1'b1;
        out_ready = rdy;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || dp_init !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept: in_ready=%b dp_init=%b, want 1/1", name, in_ready, dp_init);
        end
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            next_cyc();
            in_valid = 1'b0;
            @(negedge clk);
            if (out_valid === 1'b1) lat = n;
        end
        n_vec++;
        if (lat != 21) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles (0 = timeout), want 21", name, lat);
        end
        n_vec++;
        if (dp_state !== ct) begin
            n_err++;
            $display("FAIL %s ciphertext: got %h want %h", name, dp_state, ct);
        end
    endtask

    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        load_block(PT_C, K_C);
        next_cyc();
        next_cyc();
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (obs !== 11'b100_0000_0000 || s_obs !== 11'b100_0000_0000) begin
            n_err++;
            $display("FAIL reset: obs=%b small=%b, want 10000000000", obs, s_obs);
        end
    endtask

    task automatic test_timing();
        logic [10:0] exp;
        logic [3:0]  r;
        next_cyc();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            if (k > 0) begin
                next_cyc();
                in_valid = 1'b0;
            end
            @(negedge clk);
            r   = (k >= 1 && k <= 20) ? 4'((k + 1) / 2) : 4'd0;
            exp = {k == 0 || k >= 22, k == 21, k == 0, k >= 1 && k <= 20,
                   k >= 2 && k <= 20 && k % 2 == 0, r, k == 19 || k == 20, k >= 1 && k <= 21};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL timing T+%0d: obs=%b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_fips();
        run_block("fips_c1", PT_C, K_C, CT_C, 1'b1);
    endtask

    task automatic test_backpressure();
        run_block("bp_block", PT_B, K_B, CT_B, 1'b0);
        for (int k = 0; k < 5; k++) begin
            next_cyc();
            in_valid = k[0];
            @(negedge clk);
            n_vec++;
            if (obs !== 11'b010_0000_0001 || dp_state !== CT_B) begin
                n_err++;
                $display("FAIL bp_hold %0d: obs=%b want 01000000001 state=%h", k, obs, dp_state);
            end
        end
        next_cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
        end
        next_cyc();
        @(negedge clk);
        n_vec++;
        if (obs !== 11'b100_0000_0000) begin
            n_err++;
            $display("FAIL bp_idle: obs=%b want 10000000000", obs);
        end
        run_block("bp_next", PT_C, K_C, CT_C, 1'b1);
    endtask

    task automatic test_abort();
        int   seen;
        logic stray;
        seen = 0;
        stray = 1'b0;
        load_block(PT_B, K_B);
        next_cyc();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 40 && seen == 0; n++) begin
            next_cyc();
            in_valid = 1'b0;
            @(negedge clk);
            if (dp_round === 4'd5) seen = 1;
        end
        n_vec++;
        if (seen == 0) begin
            n_err++;
            $display("FAIL abort_reach: dp_round never reached 5 (last %0d)", dp_round);
        end
        next_cyc();
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (obs !== 11'b100_0000_0000) begin
            n_err++;
            $display("FAIL abort_idle: obs=%b want 10000000000", obs);
        end
        for (int n = 0; n < 30; n++) begin
            next_cyc();
            @(negedge clk);
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        n_vec++;
        if (stray) begin
            n_err++;
            $display("FAIL abort_silent: out_valid seen after reset, want none");
        end
        run_block("abort_next", PT_C, K_C, CT_C, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        next_cyc();
        s_in_valid  = 1'b1;
        s_out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) next_cyc();
            @(negedge clk);
            case (k % 3)
                0:       exp = 11'b101_0000_0000;
                1:       exp = 11'b000_1100_0111;
                default: exp = 11'b010_0000_0001;
            endcase
            n_vec++;
            if (s_obs !== exp) begin
                n_err++;
                $display("FAIL small_b2b T+%0d: obs=%b want %b", k, s_obs, exp);
            end
        end
        next_cyc();
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_fips();
        test_backpressure();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_aes_round_ctrl
